layer2_argmax: RTL



---
 rtl/layer2_argmax.sv | 129 ++++++++++++
 1 files changed

// File: rtl/layer2_argmax.sv
// layer2_argmax: sequential argmax over one vector of N_CLASSES ReLU'd
// single-precision node outputs. A vector is captured on a valid/ready
// handshake and scanned one element per clock, keeping the first strictly
// largest value. The result is held until the consumer takes it.
//
// Elements with the sign bit set are treated as +0. All other patterns are
// non-negative floats, so they are ordered as plain 32-bit unsigned integers
// and no float unit is needed. Inf/NaN patterns compare by their raw bits.
//
// Optional build macro ARGMAX_NOFIRE_EN adds a no_fire output. When the
// maximum is zero, no_fire is 1 and class_idx reports the "unclassified"
// bin N_CLASSES-1. When the macro is undefined, there is no no_fire port and
// an all-zero vector reports class_idx 0.
module layer2_argmax #(
   parameter int N_CLASSES = 5,
   parameter int IDX_W     = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [32*N_CLASSES-1:0]   in_vec,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [IDX_W-1:0]          class_idx,
   output logic [31:0]               max_val,
   output logic                      out_valid,
   input  logic                      out_ready
`ifdef ARGMAX_NOFIRE_EN
   ,
   output logic                      no_fire
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);
   localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

   logic [1:0]               state;
   logic [32*N_CLASSES-1:0]  vec_q;
   logic [IDX_W-1:0]         scan_idx;
   logic [IDX_W-1:0]         best_idx;
   logic [31:0]              best_val;
   logic [31:0]              cur_el;
   logic [31:0]              cur_san;
   logic                     take;
   logic                     accept;
   logic                     zero_max;

   function automatic logic [31:0] sanitise(input logic [31:0] v);
      return v[31] ? '0 : v;
   endfunction

   // Ready only in IDLE and never while reset is asserted.
   always_comb begin
      in_ready = rst_n && (state == IDLE);
      accept   = in_valid && in_ready;
   end

   // Select the element under the scan pointer from the captured vector.
   always_comb begin
      cur_el = '0;
      for (int unsigned k = 0; k < N_CLASSES; k++) begin
         if (scan_idx == IDX_W'(k)) cur_el = vec_q[32*k +: 32];
      end
      cur_san = sanitise(cur_el);
      take    = cur_san > best_val;
   end

   // Capture, scan and hold FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         vec_q    <= '0;
         scan_idx <= '0;
         best_idx <= '0;
         best_val <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  vec_q    <= in_vec;
                  best_val <= sanitise(in_vec[31:0]);
                  best_idx <= '0;
                  scan_idx <= ONE_IDX;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               if (take) begin
                  best_val <= cur_san;
                  best_idx <= scan_idx;
               end
               if (scan_idx == LAST_IDX) begin
                  scan_idx <= '0;
                  state    <= DONE;
               end else begin
                  scan_idx <= scan_idx + ONE_IDX;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Result presentation; the result registers stay stable while DONE.
   always_comb begin
      out_valid = (state == DONE);
      max_val   = best_val;
      zero_max  = out_valid && (best_val == '0);
`ifdef ARGMAX_NOFIRE_EN
      no_fire   = zero_max;
      class_idx = zero_max ? LAST_IDX : best_idx;
`else
      class_idx = best_idx;
`endif
   end

`ifndef ARGMAX_NOFIRE_EN
   logic unused_ok;
   // Flag only has a consumer in the no-fire build.
   always_comb unused_ok = zero_max;
`endif

endmodule
